// File: rtl/ddr2_sdram_responder.sv
// Simplified clk-synchronous DDR2 SDRAM device model: decodes the command bus, tracks open rows,
// returns 8-beat read bursts and absorbs DM-masked 8-beat write bursts into local storage.
module ddr2_sdram_responder #(
    parameter int unsigned RL     = 16,
    parameter int unsigned WL     = 16,
    parameter int unsigned T_RP   = 10,
    parameter int unsigned MEM_AW = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs_bar,
    input  logic        ras_bar,
    input  logic        cas_bar,
    input  logic        we_bar,
    input  logic [2:0]  BA,
    input  logic [13:0] A,
    input  logic [1:0]  DM,
    input  logic [15:0] DQ_in,
    output logic [15:0] DQ_out,
    output logic [1:0]  DQS_out,
    output logic        dq_oe,
    output logic [7:0]  bank_open,
    output logic        protocol_err
);

    localparam int unsigned MaxLat   = (RL > WL) ? RL : WL;
    localparam int unsigned CntW     = $clog2(MaxLat + 9);
    localparam int unsigned TrpW     = (T_RP > 0) ? $clog2(T_RP + 1) : 1;
    localparam int unsigned MemDepth = 1 << MEM_AW;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StRdBurst,
        StWrWait,
        StWrBurst
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TrpW-1:0]   trp_q, trp_d;
    logic [7:0]        bank_open_q, bank_open_d;
    logic [12:0]       open_row_q [8];
    logic [12:0]       open_row_d [8];
    logic [2:0]        lat_ba_q, lat_ba_d;
    logic [9:0]        lat_col_q, lat_col_d;
    logic              lat_ap_q, lat_ap_d;
    logic [15:0]       dq_out_q, dq_out_d;
    logic [1:0]        dqs_q, dqs_d;
    logic              dq_oe_q, dq_oe_d;
    logic              perr_q, perr_d;

    logic [15:0]       mem_q [MemDepth];

    logic [3:0]        cmd;
    logic              is_nop, is_act, is_rd, is_wr, is_pre;
    logic [CntW-1:0]   beat_full;
    logic [2:0]        beat;
    logic [2:0]        col_lo;
    logic [25:0]       idx_full;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       mem_rdata;
    logic              mem_we;
    logic              unused_bits;

    assign cmd    = {cs_bar, ras_bar, cas_bar, we_bar};
    assign is_nop = cs_bar | (cmd == 4'b0111);
    assign is_act = (cmd == 4'b0011);
    assign is_rd  = (cmd == 4'b0101);
    assign is_wr  = (cmd == 4'b0100);
    assign is_pre = (cmd == 4'b0010);

    // Beats walk the 8-word aligned block starting at the latched column, wrapping inside it.
    assign beat_full = cnt_q - ((state_q == StWrBurst) ? CntW'(WL) : CntW'(RL));
    assign beat      = beat_full[2:0];
    assign col_lo    = lat_col_q[2:0] + beat;
    assign idx_full  = {lat_ba_q, open_row_q[lat_ba_q], lat_col_q[9:3], col_lo};
    assign mem_addr  = idx_full[MEM_AW-1:0];
    assign mem_rdata = mem_q[mem_addr];

    assign unused_bits = ^{A[13], beat_full[CntW-1:3], idx_full[25:MEM_AW]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        trp_d       = (trp_q != '0) ? trp_q - TrpW'(1) : trp_q;
        bank_open_d = bank_open_q;
        open_row_d  = open_row_q;
        lat_ba_d    = lat_ba_q;
        lat_col_d   = lat_col_q;
        lat_ap_d    = lat_ap_q;
        dq_out_d    = dq_out_q;
        dqs_d       = dqs_q;
        dq_oe_d     = dq_oe_q;
        perr_d      = 1'b0;
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (is_act) begin
                    if (bank_open_q[BA] || (trp_q != '0)) begin
                        perr_d = 1'b1;
                    end else begin
                        bank_open_d[BA] = 1'b1;
                        open_row_d[BA]  = A[12:0];
                    end
                end else if (is_rd || is_wr) begin
                    if (!bank_open_q[BA]) begin
                        perr_d = 1'b1;
                    end else begin
                        lat_ba_d  = BA;
                        lat_col_d = A[9:0];
                        lat_ap_d  = A[10];
                        cnt_d     = CntW'(1);
                        state_d   = is_rd ? StRdWait : StWrWait;
                    end
                end else if (is_pre) begin
                    if (A[10]) begin
                        bank_open_d = '0;
                    end else begin
                        bank_open_d[BA] = 1'b0;
                    end
                end else if (!is_nop) begin
                    perr_d = 1'b1;
                end
            end
            StRdWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(RL - 1)) begin
                    dq_oe_d = 1'b1;
                    dqs_d   = 2'b00;
                    state_d = StRdBurst;
                end
            end
            StRdBurst: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(RL + 8)) begin
                    // Postamble edge: release the bus but keep the last data word.
                    dq_oe_d = 1'b0;
                    dqs_d   = 2'b00;
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    dq_out_d = mem_rdata;
                    dqs_d    = beat[0] ? 2'b00 : 2'b11;
                    if (beat == 3'd7 && lat_ap_q) begin
                        bank_open_d[lat_ba_q] = 1'b0;
                        trp_d                 = TrpW'(T_RP);
                    end
                end
            end
            StWrWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WL - 1)) begin
                    state_d = StWrBurst;
                end
            end
            StWrBurst: begin
                cnt_d  = cnt_q + CntW'(1);
                mem_we = 1'b1;
                if (beat == 3'd7) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (lat_ap_q) begin
                        bank_open_d[lat_ba_q] = 1'b0;
                        trp_d                 = TrpW'(T_RP);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Any command other than NOP while a burst is pending is rejected.
        if (state_q != StIdle && !is_nop) begin
            perr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            trp_q       <= '0;
            bank_open_q <= '0;
            for (int b = 0; b < 8; b++) begin
                open_row_q[b] <= '0;
            end
            lat_ba_q    <= '0;
            lat_col_q   <= '0;
            lat_ap_q    <= 1'b0;
            dq_out_q    <= '0;
            dqs_q       <= '0;
            dq_oe_q     <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trp_q       <= trp_d;
            bank_open_q <= bank_open_d;
            open_row_q  <= open_row_d;
            lat_ba_q    <= lat_ba_d;
            lat_col_q   <= lat_col_d;
            lat_ap_q    <= lat_ap_d;
            dq_out_q    <= dq_out_d;
            dqs_q       <= dqs_d;
            dq_oe_q     <= dq_oe_d;
            perr_q      <= perr_d;
        end
    end

    // Storage survives reset; byte lanes are written only where DM is low.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (!DM[0]) begin
                mem_q[mem_addr][7:0] <= DQ_in[7:0];
            end
            if (!DM[1]) begin
                mem_q[mem_addr][15:8] <= DQ_in[15:8];
            end
        end
    end

    assign DQ_out       = dq_out_q;
    assign DQS_out      = dqs_q;
    assign dq_oe        = dq_oe_q;
    assign bank_open    = bank_open_q;
    assign protocol_err = perr_q;

endmodule
